dec_ser_arbiter: RTL and testbench

DEC_SER_ARBITER -- requirements
Module: dec_ser_arbiter

---
 rtl/dec_ser_pkg.sv | 21 ++
 rtl/dec_ser_chan_buf.sv | 40 ++++
 rtl/dec_ser_arbiter.sv | 144 ++++++++++++++
 tb/tb_dec_ser_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_ser_pkg.sv
// Shared constants and types for the two-channel decimator serializer.
package dec_ser_pkg;
   localparam int DATA_W_DEF = 22;
   localparam int FRAME_LEN  = DATA_W_DEF + 1;
   localparam int CNT_W      = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   function automatic int frame_len_for(input int data_w);
      return data_w + 1;
   endfunction

   // Counter holds the number of bits still to go after the id bit, max data_w.
   function automatic int cnt_w_for(input int data_w);
      return $clog2(data_w + 1);
   endfunction
endpackage

// File: rtl/dec_ser_chan_buf.sv
// One-entry holding register per decimator channel with pending flag and sticky overflow.
// A capture in the same cycle as a grant refills the entry without counting as overflow.
module dec_ser_chan_buf
   import dec_ser_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample,
   input  logic              valid,
   input  logic              grant,
   input  logic              ovf_clr,
   output logic [DATA_W-1:0] held,
   output logic              pending,
   output logic              ovf
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held    <= '0;
         pending <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (valid) begin
            held    <= sample;
            pending <= 1'b1;
         end else if (grant) begin
            pending <= 1'b0;
         end

         // A new overflow outranks a simultaneous clear.
         if (valid && pending && !grant)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/dec_ser_arbiter.sv
// Round-robin arbiter and serializer: two decimator channels share one serial line,
// each frame is the channel id bit followed by the sample MSB first.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | line quiet, waiting for a pending entry
//   ST_SHIFT | frame on data_o, one bit per cycle, id bit first
//   ST_GAP   | forced quiet cycles between frames (GAP of them)
module dec_ser_arbiter
   import dec_ser_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int GAP    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ch0_data_i,
   input  logic              ch0_valid_i,
   input  logic [DATA_W-1:0] ch1_data_i,
   input  logic              ch1_valid_i,
   input  logic              ovf_clr_i,
   output logic              data_o,
   output logic              frame_sync_o,
   output logic              busy_o,
   output logic [1:0]        ovf_o
);

   localparam int              BIT_W     = cnt_w_for(DATA_W);
   localparam int              FRM_LEN   = frame_len_for(DATA_W);
   localparam logic [BIT_W-1:0] DATA_CNT = BIT_W'(FRM_LEN - 1);
   localparam logic [2:0]      GAP_LOAD  = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

   state_t              state;
   logic [DATA_W-1:0]   sreg;
   logic [BIT_W-1:0]    bit_cnt;
   logic [2:0]          gap_cnt;
   logic                last_grant;

   logic [DATA_W-1:0]   held0, held1;
   logic [1:0]          pend;
   logic                pick;
   logic                load;
   logic [DATA_W:0]     frame;

   dec_ser_chan_buf #(.DATA_W(DATA_W)) u_buf0 (
      .clk     (clk),
      .rst     (rst),
      .sample  (ch0_data_i),
      .valid   (ch0_valid_i),
      .grant   (load & ~pick),
      .ovf_clr (ovf_clr_i),
      .held    (held0),
      .pending (pend[0]),
      .ovf     (ovf_o[0])
   );

   dec_ser_chan_buf #(.DATA_W(DATA_W)) u_buf1 (
      .clk     (clk),
      .rst     (rst),
      .sample  (ch1_data_i),
      .valid   (ch1_valid_i),
      .grant   (load & pick),
      .ovf_clr (ovf_clr_i),
      .held    (held1),
      .pending (pend[1]),
      .ovf     (ovf_o[1])
   );

   // Loading can happen from IDLE, or straight out of the last data bit when GAP is 0.
   always_comb begin
      pick = pend[1];
      if (pend == 2'b11)
         pick = ~last_grant;
      load = 1'b0;
      if (pend != 2'b00) begin
         if (state == ST_IDLE)
            load = 1'b1;
         else if (state == ST_SHIFT && bit_cnt == '0 && GAP == 0)
            load = 1'b1;
      end
      frame = pick ? {1'b1, held1} : {1'b0, held0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         sreg         <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         last_grant   <= 1'b1;
         data_o       <= 1'b0;
         frame_sync_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         frame_sync_o <= 1'b0;
         if (load) begin
            state        <= ST_SHIFT;
            data_o       <= frame[DATA_W];
            sreg         <= frame[DATA_W-1:0];
            bit_cnt      <= DATA_CNT;
            last_grant   <= pick;
            frame_sync_o <= 1'b1;
            busy_o       <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  data_o <= 1'b0;
                  busy_o <= 1'b0;
               end
               ST_SHIFT: begin
                  if (bit_cnt != '0) begin
                     data_o  <= sreg[DATA_W-1];
                     sreg    <= {sreg[DATA_W-2:0], 1'b0};
                     bit_cnt <= bit_cnt - 1'b1;
                  end else if (GAP > 0) begin
                     state   <= ST_GAP;
                     data_o  <= 1'b0;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state  <= ST_IDLE;
                     data_o <= 1'b0;
                     busy_o <= 1'b0;
                  end
               end
               ST_GAP: begin
                  data_o <= 1'b0;
                  if (gap_cnt == '0) begin
                     state  <= ST_IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
               default: begin
                  state  <= ST_IDLE;
                  data_o <= 1'b0;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dec_ser_arbiter.sv
// Directed bench for dec_ser_arbiter: one instance with GAP=1, one with GAP=0, shared stimulus,
// frames deserialized from the line and compared against hand-computed values.
module tb_dec_ser_arbiter;
   localparam int DW = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] ch0_data = '0, ch1_data = '0;
   logic          ch0_valid = 1'b0, ch1_valid = 1'b0, ovf_clr = 1'b0;
   logic          data1, fs1, busy1;
   logic [1:0]    ovf1;
   logic          data0, fs0, busy0;
   logic [1:0]    ovf0;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   logic [DW:0] q1[$], q0[$];
   int          s1[$], s0[$];
   logic [DW:0] exp_q[$];
   logic [DW:0] m1_sr, m0_sr;
   int          m1_cnt = 0, m0_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dec_ser_arbiter #(.DATA_W(DW), .GAP(1)) u_dut (
      .clk(clk), .rst(rst),
      .ch0_data_i(ch0_data), .ch0_valid_i(ch0_valid),
      .ch1_data_i(ch1_data), .ch1_valid_i(ch1_valid),
      .ovf_clr_i(ovf_clr),
      .data_o(data1), .frame_sync_o(fs1), .busy_o(busy1), .ovf_o(ovf1)
   );

   dec_ser_arbiter #(.DATA_W(DW), .GAP(0)) u_dut_nogap (
      .clk(clk), .rst(rst),
      .ch0_data_i(ch0_data), .ch0_valid_i(ch0_valid),
      .ch1_data_i(ch1_data), .ch1_valid_i(ch1_valid),
      .ovf_clr_i(ovf_clr),
      .data_o(data0), .frame_sync_o(fs0), .busy_o(busy0), .ovf_o(ovf0)
   );

   always @(negedge clk) begin
      if (rst) m1_cnt = 0;
      else if (fs1) begin
         m1_sr  = {{DW{1'b0}}, data1};
         m1_cnt = 1;
         s1.push_back(cyc);
      end else if (m1_cnt != 0) begin
         m1_sr = {m1_sr[DW-1:0], data1};
         m1_cnt++;
         if (m1_cnt == DW + 1) begin
            q1.push_back(m1_sr);
            m1_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) m0_cnt = 0;
      else if (fs0) begin
         m0_sr  = {{DW{1'b0}}, data0};
         m0_cnt = 1;
         s0.push_back(cyc);
      end else if (m0_cnt != 0) begin
         m0_sr = {m0_sr[DW-1:0], data0};
         m0_cnt++;
         if (m0_cnt == DW + 1) begin
            q0.push_back(m0_sr);
            m0_cnt = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q1.delete(); q0.delete(); s1.delete(); s0.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ch0_valid = 1'b0; ch1_valid = 1'b0; ovf_clr = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      clear_q();
   endtask

   task automatic pulse(input logic ch, input logic [DW-1:0] val);
      if (ch) begin ch1_data = val; ch1_valid = 1'b1; end
      else    begin ch0_data = val; ch0_valid = 1'b1; end
      tick(1);
      ch0_valid = 1'b0; ch1_valid = 1'b0;
   endtask

   task automatic wait_sync(input int budget);
      int k = 0;
      while (fs1 !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("sync_seen", 32'(fs1), 32'd1);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while ((q1.size() < n || q0.size() < n || busy1 || busy0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("frames_gap1", 32'(q1.size() >= n), 32'd1);
      chk("frames_gap0", 32'(q0.size() >= n), 32'd1);
   endtask

   initial begin
      logic [DW:0] frm;
      int          fs_cnt, busy_lo;
      logic [3:0]  ids;
      logic [DW-1:0] a, b;

      // reset state, checked before the first clock edge
      #2;
      chk("rst_gap1", {28'd0, data1, fs1, busy1, ovf1}, 32'd0);
      chk("rst_gap0", {28'd0, data0, fs0, busy0, ovf0}, 32'd0);
      do_reset();

      // single sample: latency, bit order, gap, busy duration
      ch0_data = 22'h2AAAAA; ch0_valid = 1'b1;
      tick(1);
      ch0_valid = 1'b0;
      @(negedge clk);
      chk("lat_early", {31'd0, fs1}, 32'd0);
      @(negedge clk);
      chk("lat_sync", {30'd0, fs1, busy1}, 32'd3);
      frm = {{DW{1'b0}}, data1};
      fs_cnt = 0; busy_lo = 0;
      for (int i = 1; i <= DW; i++) begin
         @(negedge clk);
         frm = {frm[DW-1:0], data1};
         fs_cnt += int'(fs1);
         busy_lo += int'(!busy1);
      end
      chk("single_frame", 32'(frm), 32'({1'b0, 22'h2AAAAA}));
      chk("single_fs_once", 32'(fs_cnt), 32'd0);
      chk("single_busy", 32'(busy_lo), 32'd0);
      @(negedge clk);
      chk("single_gap", {30'd0, data1, busy1}, 32'd1);
      @(negedge clk);
      chk("single_idle", {29'd0, data1, fs1, busy1}, 32'd0);

      // simultaneous strobes: ch0 first, then ch1
      do_reset();
      ch0_data = 22'h000001; ch1_data = 22'h3FFFFF;
      ch0_valid = 1'b1; ch1_valid = 1'b1;
      tick(1);
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      wait_frames(2, 200);
      if (q1.size() >= 2 && q0.size() >= 2) begin
         chk("sim_first", 32'(q1[0]), 32'({1'b0, 22'h000001}));
         chk("sim_second", 32'(q1[1]), 32'({1'b1, 22'h3FFFFF}));
         chk("sim_spacing_gap1", 32'(s1[1] - s1[0]), 32'd25);
         chk("sim_first_gap0", 32'(q0[0]), 32'({1'b0, 22'h000001}));
         chk("sim_second_gap0", 32'(q0[1]), 32'({1'b1, 22'h3FFFFF}));
         chk("sim_spacing_gap0", 32'(s0[1] - s0[0]), 32'd23);
      end
      chk("sim_ovf", {28'd0, ovf1, ovf0}, 32'd0);

      // capture in the grant cycle: old sample goes out, new one is kept, no overflow
      do_reset();
      ch0_data = 22'h0ABCDE; ch0_valid = 1'b1;
      tick(1);
      ch0_data = 22'h155555;
      tick(1);
      ch0_valid = 1'b0;
      wait_frames(2, 200);
      if (q1.size() >= 2 && q0.size() >= 2) begin
         chk("grant_old", 32'(q1[0]), 32'({1'b0, 22'h0ABCDE}));
         chk("grant_new", 32'(q1[1]), 32'({1'b0, 22'h155555}));
         chk("grant_new_gap0", 32'(q0[1]), 32'({1'b0, 22'h155555}));
      end
      chk("grant_ovf", {28'd0, ovf1, ovf0}, 32'd0);

      // fairness under continuous demand
      do_reset();
      ch0_valid = 1'b1; ch1_valid = 1'b1;
      for (int i = 0; i < 110; i++) begin
         ch0_data = DW'(i);
         ch1_data = DW'(i + 1000);
         tick(1);
      end
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      wait_frames(4, 400);
      if (q1.size() >= 4) begin
         ids = {q1[0][DW], q1[1][DW], q1[2][DW], q1[3][DW]};
         chk("fair_ids", 32'(ids), 32'b0101);
      end
      if (q0.size() >= 4) begin
         ids = {q0[0][DW], q0[1][DW], q0[2][DW], q0[3][DW]};
         chk("fair_ids_gap0", 32'(ids), 32'b0101);
      end
      chk("fair_ovf", 32'(ovf1), 32'b11);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("fair_ovf_clr", 32'(ovf1), 32'd0);

      // overflow on ch1 while ch0 shifts, then clear, then set-wins-over-clear
      do_reset();
      pulse(1'b0, 22'h012345);
      wait_sync(10);
      tick(3);
      pulse(1'b1, 22'h000010);
      tick(2);
      pulse(1'b1, 22'h000020);
      chk("ovf_set", {28'd0, ovf1, ovf0}, 32'b1010);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clear", 32'(ovf1), 32'd0);
      ch1_data = 22'h000020; ch1_valid = 1'b1; ovf_clr = 1'b1;
      tick(1);
      ch1_valid = 1'b0; ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(ovf1), 32'b10);
      wait_frames(2, 200);
      if (q1.size() >= 2) begin
         chk("ovf_f0", 32'(q1[0]), 32'({1'b0, 22'h012345}));
         chk("ovf_f1", 32'(q1[1]), 32'({1'b1, 22'h000020}));
      end
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_final_clr", {28'd0, ovf1, ovf0}, 32'd0);

      // reset in the middle of a frame
      do_reset();
      pulse(1'b0, 22'h3FFFFF);
      wait_sync(10);
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst", {30'd0, data1, busy1}, 32'b11);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst", {26'd0, data1, fs1, busy1, data0, fs0, busy0}, 32'd0);
      tick(2);
      rst = 1'b0;
      clear_q();
      tick(60);
      chk("no_frame_after_rst", 32'(s1.size() + s0.size()), 32'd0);
      chk("idle_after_rst", {31'd0, busy1}, 32'd0);
      pulse(1'b1, 22'h000155);
      wait_frames(1, 100);
      if (q1.size() >= 1)
         chk("frame_after_rst", 32'(q1[0]), 32'({1'b1, 22'h000155}));

      // decimator rate: both channels every 256 cycles
      do_reset();
      exp_q.delete();
      for (int k = 0; k < 75; k++) begin
         a = DW'($urandom);
         b = DW'($urandom);
         exp_q.push_back({1'b0, a});
         exp_q.push_back({1'b1, b});
         ch0_data = a; ch1_data = b;
         ch0_valid = 1'b1; ch1_valid = 1'b1;
         tick(1);
         ch0_valid = 1'b0; ch1_valid = 1'b0;
         tick(255);
      end
      wait_frames(150, 300);
      chk("dec_count", 32'(q1.size()), 32'd150);
      chk("dec_count_gap0", 32'(q0.size()), 32'd150);
      for (int i = 0; i < 150; i++) begin
         if (i < q1.size()) chk($sformatf("dec_%0d", i), 32'(q1[i]), 32'(exp_q[i]));
         if (i < q0.size()) chk($sformatf("dec0_%0d", i), 32'(q0[i]), 32'(exp_q[i]));
      end
      chk("dec_ovf", {28'd0, ovf1, ovf0}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
